// File: rtl/fixed_point_pack.sv
// Serial-to-parallel packer: collects NUM_OUTPUTS fixed-point elements into one registered vector.
// Optional macro FIXED_POINT_PACK_LAST_EN adds LAST_IN to close a short vector early.
module fixed_point_pack #(
    parameter int WIDTH       = 8,
    parameter int FRAC_BITS   = 3,
    parameter int NUM_OUTPUTS = 16
) (
    input  logic                                 CLK,
    input  logic                                 RSTN,
    input  logic signed [WIDTH-1:0]              VALUE_IN,
    input  logic                                 VALID_IN,
    output logic                                 READY_OUT,
    output logic signed [NUM_OUTPUTS*WIDTH-1:0]  VALUES_OUT,
    output logic                                 VALID_OUT,
`ifdef FIXED_POINT_PACK_LAST_EN
    input  logic                                 LAST_IN,
`endif
    input  logic                                 DONE_IN
);

    localparam int            CW       = (NUM_OUTPUTS > 1) ? $clog2(NUM_OUTPUTS) : 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(NUM_OUTPUTS - 1);
    localparam bit            CFG_OK   = (FRAC_BITS >= 1) && (FRAC_BITS < WIDTH) && (NUM_OUTPUTS >= 2);

    generate
        if (!CFG_OK) begin : g_cfg_err
            $error("fixed_point_pack: illegal FRAC_BITS/NUM_OUTPUTS configuration");
        end
    endgenerate

    typedef enum logic [1:0] {
        FILL    = 2'd0,
        PRESENT = 2'd1,
        HOLD    = 2'd2
    } state_t;

    state_t            state_r;
    state_t            state_s;
    logic [CW-1:0]     count_r;
    logic [CW-1:0]     count_s;
    logic [WIDTH-1:0]  slot_r [NUM_OUTPUTS];
    logic              ready_r;
    logic              valid_r;
    logic              accept_s;
    logic              final_s;
    logic              clear_s;

    // Decide whether the element at the current count closes the vector.
    always_comb begin
`ifdef FIXED_POINT_PACK_LAST_EN
        final_s = (count_r == LAST_IDX) || LAST_IN;
`else
        final_s = (count_r == LAST_IDX);
`endif
    end

    // Next-state, counter and slot-control decode.
    always_comb begin
        state_s  = state_r;
        count_s  = count_r;
        accept_s = 1'b0;
        clear_s  = 1'b0;
        case (state_r)
            FILL: begin
                if (VALID_IN && ready_r) begin
                    accept_s = 1'b1;
                    if (final_s) begin
                        state_s = PRESENT;
                    end else begin
                        count_s = count_r + CW'(1);
                    end
                end else begin
                    state_s = FILL;
                end
            end
            PRESENT: begin
                state_s = HOLD;
            end
            HOLD: begin
                if (DONE_IN) begin
                    state_s = FILL;
                    count_s = '0;
                    clear_s = 1'b1;
                end else begin
                    state_s = HOLD;
                end
            end
            default: begin
                state_s = FILL;
                count_s = '0;
                clear_s = 1'b1;
            end
        endcase
    end

    // State, counter and handshake registers; ready is registered so it stays low through reset.
    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            state_r <= FILL;
            count_r <= '0;
            ready_r <= 1'b0;
            valid_r <= 1'b0;
        end else begin
            state_r <= state_s;
            count_r <= count_s;
            ready_r <= (state_s == FILL);
            valid_r <= (state_s == PRESENT);
        end
    end

    generate
        for (genvar k = 0; k < NUM_OUTPUTS; k++) begin : g_slot
            // Slot k: cleared on reset or release, loaded when the fill count points at it.
            always_ff @(posedge CLK) begin
                if (!RSTN || clear_s) begin
                    slot_r[k] <= '0;
                end else if (accept_s && (count_r == CW'(k))) begin
                    slot_r[k] <= VALUE_IN;
                end else begin
                    slot_r[k] <= slot_r[k];
                end
            end

            assign VALUES_OUT[k*WIDTH +: WIDTH] = slot_r[k];
        end
    endgenerate

    assign READY_OUT = ready_r;
    assign VALID_OUT = valid_r;

endmodule

// File: doc/fixed_point_pack.md
FIXED_POINT_PACK -- requirements
Module: FIXED_POINT_PACK

Interface
REQ-001 SHALL have parameter WIDTH, default 8, bit width of each fixed-point element.
REQ-002 SHALL have parameter FRAC_BITS, default 3, fractional bits; informational only, no arithmetic; legal range 1..WIDTH-1.
REQ-003 SHALL have parameter NUM_OUTPUTS, default 16, number of elements in the packed output vector; legal value >= 2.
REQ-004 SHALL have port CLK  input  1  sole clock, all logic on rising edge.
REQ-005 SHALL have port RSTN  input  1  synchronous active-low reset.
REQ-006 SHALL have port VALUE_IN  input  WIDTH (signed)  serial input element.
REQ-007 SHALL have port VALID_IN  input  1  VALUE_IN qualifier.
REQ-008 SHALL have port READY_OUT  output  1  block can accept an element this cycle.
REQ-009 SHALL have port VALUES_OUT  output  NUM_OUTPUTS*WIDTH (signed)  packed vector; element k at bits [k*WIDTH +: WIDTH].
REQ-010 SHALL have port VALID_OUT  output  1  single-cycle pulse: vector complete.
REQ-011 SHALL have port DONE_IN  input  1  downstream consumer finished reading VALUES_OUT; releases the vector.

Function
REQ-012 SHALL implement a state machine with states FILL, PRESENT and HOLD.
REQ-013 An element SHALL be accepted on a rising edge where VALID_IN=1 and READY_OUT=1; VALID_IN with READY_OUT=0 is ignored (no data captured).
REQ-014 The element accepted at fill count c SHALL be written to slot c, so the first accepted element lands in slot 0; counter then increments by 1.
REQ-015 READY_OUT SHALL be 1 only in FILL and 0 in PRESENT and HOLD.
REQ-016 On acceptance of the element with count NUM_OUTPUTS-1, state SHALL go to PRESENT on the next cycle; the counter never wraps past NUM_OUTPUTS-1.
REQ-017 In PRESENT, VALID_OUT SHALL be 1 for exactly one cycle, then state goes to HOLD.
REQ-018 In HOLD, VALUES_OUT SHALL stay bit-stable until DONE_IN is sampled 1.
REQ-019 DONE_IN sampled 1 in HOLD SHALL clear all slots to zero and the counter to 0, and SHALL move to FILL; READY_OUT is 1 on the following cycle.
REQ-020 DONE_IN SHALL be ignored in FILL and PRESENT, including when asserted in the same cycle as VALID_OUT.
REQ-021 VALUES_OUT SHALL be driven directly from registers, with no combinational path from VALUE_IN.
REQ-022 Slots not yet written in the current fill SHALL read zero.
REQ-023 Latency SHALL be one cycle from the last element accepted to VALID_OUT=1.
REQ-024 Sustained throughput SHALL be one vector per NUM_OUTPUTS+2 cycles when DONE_IN is asserted immediately in HOLD.

Reset
REQ-025 While RSTN=0 at a rising edge: state SHALL be FILL, counter 0, all VALUES_OUT bits 0, VALID_OUT 0.
REQ-026 READY_OUT SHALL be 0 while RSTN=0 and 1 from the first cycle after RSTN returns to 1.
REQ-027 Reset asserted mid-fill or in HOLD SHALL discard partial or held data with no VALID_OUT pulse.

Configuration
REQ-028 Macro FIXED_POINT_PACK_LAST_EN SHALL, when defined, add port LAST_IN  input  1  marks the final element of a short vector.
REQ-029 With FIXED_POINT_PACK_LAST_EN defined, accepting an element with LAST_IN=1 at any count c SHALL store it in slot c, leave slots c+1..NUM_OUTPUTS-1 zero, and go to PRESENT.
REQ-030 With FIXED_POINT_PACK_LAST_EN defined, LAST_IN=1 at count NUM_OUTPUTS-1 SHALL behave identically to a normal full fill.
REQ-031 Without FIXED_POINT_PACK_LAST_EN, LAST_IN SHALL not exist and a vector completes only after NUM_OUTPUTS accepted elements.

Verification
REQ-032 Full fill: NUM_OUTPUTS=4, WIDTH=8, feed 0x11,0x22,0x33,0x44 back-to-back -> VALID_OUT one cycle later, VALUES_OUT=0x44332211.
REQ-033 Gapped input: same data with VALID_IN low on alternate cycles -> identical VALUES_OUT; VALID_OUT one cycle after 0x44 is accepted.
REQ-034 Backpressure: hold DONE_IN=0 for 10 cycles after VALID_OUT while driving VALID_IN=1, VALUE_IN=0x7F -> READY_OUT=0, VALUES_OUT unchanged, nothing captured; DONE_IN=1 -> READY_OUT=1 next cycle, VALUES_OUT=0.
REQ-035 Mid-fill reset: accept 0x11,0x22, pulse RSTN=0 one cycle, then feed 0xA1..0xA4 -> VALUES_OUT=0xA4A3A2A1, no earlier VALID_OUT.
REQ-036 Macro defined: feed 0x80 then 0x05 with LAST_IN=1 -> VALUES_OUT=0x00000580, one VALID_OUT pulse.
REQ-037 Negative values: feed 0xF8 (-1.0 at FRAC_BITS=3) in all 4 slots -> VALUES_OUT=0xF8F8F8F8, stored bit-exact with no sign extension across slots.
